lut_modred_ctrl: RTL and testbench

//  Sequencer for table-driven modular reduction. Accepts a wide operand and splits it into a low
//  W_DATA-bit part plus NCHUNK CHUNK-bit high chunks. Each chunk drives one read of the shared

---
 rtl/lut_modred_ctrl.sv | 140 ++++++++++++++
 tb/tb_lut_modred_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_modred_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lut_modred_ctrl
// Description : Table-driven modular reduction sequencer. It splits the
//               operand into a low residue plus CHUNK-bit high chunks, adds
//               one LUT residue per chunk, then folds the sum below Q.
// Revision    : 1.0 - initial release
// ============================================================================
module lut_modred_ctrl #(
    parameter int              W_DATA = 49,
    parameter int              CHUNK  = 5,
    parameter int              NCHUNK = 4,
    parameter logic [W_DATA-1:0] Q    = 49'd549824583172097
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [W_DATA+CHUNK*NCHUNK-1:0]  din,
    output logic                            lut_en,
    output logic [((NCHUNK > 1) ? $clog2(NCHUNK) : 1)-1:0] lut_sel,
    output logic [CHUNK-1:0]                lut_addr,
    input  logic [W_DATA-1:0]               lut_dout,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [W_DATA-1:0]               dout,
    output logic                            busy
);

    localparam int c_SEL_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int c_ACC_W = W_DATA + $clog2(NCHUNK + 1);
    localparam int c_HI_W  = CHUNK * NCHUNK;
    localparam int c_DIN_W = W_DATA + c_HI_W;

    localparam logic [c_ACC_W-1:0] c_Q_EXT  = {{(c_ACC_W-W_DATA){1'b0}}, Q};
    localparam logic [c_SEL_W-1:0] c_LAST_K = c_SEL_W'(NCHUNK - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ISSUE  = 3'd1;
    localparam logic [2:0] c_ST_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_REDUCE = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    logic [2:0]          r_state;
    logic [c_SEL_W-1:0]  r_k;
    logic [c_HI_W-1:0]   r_chunks;
    logic [c_ACC_W-1:0]  r_acc;
    logic                r_pend;
    logic [W_DATA-1:0]   r_dout;
    logic                r_out_valid;

    logic                w_issue;
    logic [c_ACC_W-1:0]  w_acc_sum;
    logic [c_ACC_W-1:0]  w_acc_sub;
    logic                w_ge_q;

    assign w_issue   = (r_state == c_ST_ISSUE);
    assign w_acc_sum = r_acc + {{(c_ACC_W-W_DATA){1'b0}}, lut_dout};
    assign w_acc_sub = r_acc - c_Q_EXT;
    assign w_ge_q    = (r_acc >= c_Q_EXT);

    // The chunk register shifts down one chunk per issue, so the current
    // address is always its bottom CHUNK bits.
    assign lut_en    = w_issue;
    assign lut_sel   = w_issue ? r_k : '0;
    assign lut_addr  = w_issue ? r_chunks[CHUNK-1:0] : '0;

    assign in_ready  = (r_state == c_ST_IDLE);
    assign busy      = (r_state != c_ST_IDLE);
    assign out_valid = r_out_valid;
    assign dout      = r_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_k         <= '0;
            r_chunks    <= '0;
            r_acc       <= '0;
            r_pend      <= 1'b0;
            r_dout      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            // A read issued this cycle returns next cycle; the flag marks
            // that cycle so its data is folded into the accumulator.
            r_pend <= w_issue;

            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_chunks <= din[c_DIN_W-1:W_DATA];
                        r_acc    <= {{(c_ACC_W-W_DATA){1'b0}}, din[W_DATA-1:0]};
                        r_k      <= '0;
                        r_state  <= c_ST_ISSUE;
                    end
                end

                c_ST_ISSUE: begin
                    if (r_pend) begin
                        r_acc <= w_acc_sum;
                    end
                    r_chunks <= r_chunks >> CHUNK;
                    r_k      <= r_k + 1'b1;
                    if (r_k == c_LAST_K) begin
                        r_state <= c_ST_WAIT;
                    end
                end

                c_ST_WAIT: begin
                    if (r_pend) begin
                        r_acc <= w_acc_sum;
                    end
                    r_state <= c_ST_REDUCE;
                end

                c_ST_REDUCE: begin
                    if (w_ge_q) begin
                        r_acc <= w_acc_sub;
                    end else begin
                        r_dout      <= r_acc[W_DATA-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= c_ST_DONE;
                    end
                end

                c_ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lut_modred_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lut_modred_ctrl
// Description : Scoreboard bench for lut_modred_ctrl with an exact mod-Q LUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lut_modred_ctrl;

    localparam int          W_DATA = 49;
    localparam int          CHUNK  = 5;
    localparam int          NCHUNK = 4;
    localparam int          DIN_W  = W_DATA + CHUNK * NCHUNK;
    localparam logic [48:0] Q      = 49'd549824583172097;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DIN_W-1:0]  din;
    logic              lut_en;
    logic [1:0]        lut_sel;
    logic [CHUNK-1:0]  lut_addr;
    logic [W_DATA-1:0] lut_dout;
    logic              out_valid;
    logic              out_ready;
    logic [W_DATA-1:0] dout;
    logic              busy;

    typedef struct {
        logic [W_DATA-1:0] data;
        logic [19:0]       chunks;
        int                acc_cyc;
        int                lat;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   lut_cnt = 0;
    bit   prev_ov = 1'b0;
    bit   rnd_done;

    lut_modred_ctrl #(
        .W_DATA (W_DATA),
        .CHUNK  (CHUNK),
        .NCHUNK (NCHUNK),
        .Q      (Q)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .lut_en    (lut_en),
        .lut_sel   (lut_sel),
        .lut_addr  (lut_addr),
        .lut_dout  (lut_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W_DATA-1:0] lut_val(input int j, input int i);
        logic [127:0] t;
        t = 128'(i) << (W_DATA + CHUNK * j);
        return 49'(t % 128'(Q));
    endfunction

    function automatic logic [W_DATA-1:0] ref_mod(input logic [DIN_W-1:0] d);
        logic [127:0] t;
        t = 128'(d);
        return 49'(t % 128'(Q));
    endfunction

    // Latency depends on how many times Q fits in the folded sum.
    function automatic int exp_lat(input logic [DIN_W-1:0] d);
        logic [127:0] acc;
        acc = 128'(d[W_DATA-1:0]);
        for (int j = 0; j < NCHUNK; j++)
            acc = acc + 128'(lut_val(j, int'(d[W_DATA + CHUNK*j +: CHUNK])));
        return NCHUNK + 3 + int'(acc / 128'(Q));
    endfunction

    // Registered LUT bank; garbage is returned when no read was issued.
    always @(posedge clk) begin
        if (lut_en) lut_dout <= lut_val(int'(lut_sel), int'(lut_addr));
        else        lut_dout <= 49'({$urandom, $urandom});
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: LUT read sequence, output latency and data, popped in order.
    always @(negedge clk) begin
        if (rst || !busy) lut_cnt = 0;
        if (!rst) begin
            if (lut_en) begin
                if (q.size() == 0 || lut_cnt >= NCHUNK) begin
                    checks++; errors++;
                    $display("FAIL lut_en_spurious: got lut_en=1 read=%0d expected none", lut_cnt);
                end else begin
                    check("lut_sel", 128'(lut_sel), 128'(lut_cnt));
                    check("lut_addr", 128'(lut_addr), 128'(q[0].chunks[lut_cnt*CHUNK +: CHUNK]));
                end
                lut_cnt++;
            end
            if (out_valid && !prev_ov) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL out_unexpected: got out_valid=1 expected no result pending");
                end else begin
                    check("latency", 128'(cyc - q[0].acc_cyc), 128'(q[0].lat));
                end
            end
            if (out_valid && out_ready && q.size() != 0) begin
                check("dout", 128'(dout), 128'(q[0].data));
                check("lut_reads", 128'(lut_cnt), 128'(NCHUNK));
                void'(q.pop_front());
                lut_cnt = 0;
            end
        end
        prev_ov = out_valid && !rst;
    end

    task automatic send(input logic [DIN_W-1:0] d, input logic [W_DATA-1:0] e, input int lat);
        exp_t x;
        bit   ok;
        ok       = 1'b0;
        din      = d;
        in_valid = 1'b1;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                x.data    = e;
                x.chunks  = d[DIN_W-1:W_DATA];
                x.acc_cyc = cyc;
                x.lat     = lat;
                q.push_back(x);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected accept within 300 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (q.size() != 0 && n < 400);
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        logic [DIN_W-1:0] d;
        bit               seen;

        rst = 1'b1; in_valid = 1'b0; din = '0; out_ready = 1'b1; rnd_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_lut_en", 128'(lut_en), 128'(0));
        check("rst_lut_sel", 128'(lut_sel), 128'(0));
        check("rst_lut_addr", 128'(lut_addr), 128'(0));
        check("rst_dout", 128'(dout), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors with hand-derived results.
        send(69'd5, 49'd5, 7);                              drain();
        send(69'(Q), 49'd0, 8);                             drain();
        send(69'(Q) - 69'd1, Q - 49'd1, 7);                 drain();
        send(69'h1 << 49, 49'd13125370249215, 7);           drain();
        send(69'((69'h1 << 49) - 69'h1), 49'd13125370249214, 8); drain();
        d = '1;
        send(d, ref_mod(d), exp_lat(d));                    drain();

        // Output back-pressure: result held, new operand refused.
        out_ready = 1'b0;
        send(69'd12345, 49'd12345, 7);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check("hold_reached", 128'(seen), 128'(1));
        @(posedge clk); #1;
        din = 69'd999; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_out_valid", 128'(out_valid), 128'(1));
            check("hold_dout", 128'(dout), 128'(49'd12345));
            check("hold_in_ready", 128'(in_ready), 128'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(69'd999, 49'd999, 7);                          drain();

        // Reset during the third LUT issue abandons the operation.
        d = {20'hFFFFF, 49'd3};
        send(d, ref_mod(d), exp_lat(d));
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = lut_en && (lut_sel == 2'd2);
        end
        check("abort_reached", 128'(seen), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        check("abort_in_ready", 128'(in_ready), 128'(1));
        check("abort_lut_en", 128'(lut_en), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_out_valid", 128'(out_valid), 128'(0));
        @(posedge clk); #1;
        send(69'd7, 49'd7, 7);                              drain();

        // Random operands with input gaps and output back-pressure.
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    d = 69'({$urandom, $urandom, $urandom});
                    if (i % 8 == 0) d[W_DATA-1:0] = '1;
                    send(d, ref_mod(d), exp_lat(d));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
